// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the IF/MEM external SRAM arbiter.
//
// Contents:
//   state_e             - arbiter sequencing states (IDLE, ACCESS, DONE)
//   grant_e             - which requester owns the current access
//   DEFAULT_WAIT_CYCLES - default SRAM access length in clock cycles
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_IF   = 2'd1,
    G_MEM  = 2'd2
  } grant_e;

  localparam int unsigned DEFAULT_WAIT_CYCLES = 3;

endpackage : arm_mem_pkg

// File: rtl/mem_arbiter.sv
// Arbiter for a single-ported, multi-cycle external SRAM shared by the IF
// (instruction fetch) and MEM (load/store) stages of a 5-stage pipeline.
// Each access is held on the SRAM for WAIT_CYCLES cycles. Read data is
// returned to the requester. The pipeline is frozen until every request of
// the current step has been served. MEM wins over IF because it belongs to
// the older instruction.
//
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   if_req / if_addr      - fetch request (held until if_ready) and byte address
//   if_rdata / if_ready   - fetched instruction, IF served this step
//   mem_r_en / mem_w_en   - load / store request (store wins if both are set)
//   mem_addr / mem_wdata  - data byte address and store data
//   mem_rdata / mem_ready - load data, MEM served this step
//   sram_*                - word address, write data, read data, active-low strobes
//   freeze                - stalls PC and IF_Reg while any request is unserved
import arm_mem_pkg::*;

module mem_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SRAM_ADDR_W = 16,
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  // IF stage
  input  logic                   if_req,
  input  logic [ADDR_W-1:0]      if_addr,
  output logic [DATA_W-1:0]      if_rdata,
  output logic                   if_ready,
  // MEM stage
  input  logic                   mem_r_en,
  input  logic                   mem_w_en,
  input  logic [ADDR_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      mem_wdata,
  output logic [DATA_W-1:0]      mem_rdata,
  output logic                   mem_ready,
  // External SRAM
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0]      sram_wdata,
  input  logic [DATA_W-1:0]      sram_rdata,
  output logic                   sram_we_n,
  output logic                   sram_oe_n,
  // Pipeline control
  output logic                   freeze
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                 state_q, state_d;
  grant_e                 grant_q, grant_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic                   write_q, write_d;
  logic [DATA_W-1:0]      if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]      mem_rdata_q, mem_rdata_d;
  logic                   if_served_q, if_served_d;
  logic                   mem_served_q, mem_served_d;

  logic mem_req;

  // A store takes precedence when both enables are set.
  assign mem_req = mem_r_en | mem_w_en;

  // Only the word-address slice of each byte address reaches the SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[ADDR_W-1:SRAM_ADDR_W+2], if_addr[1:0],
                              mem_addr[ADDR_W-1:SRAM_ADDR_W+2], mem_addr[1:0]};

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // ready is high from the DONE cycle onwards. The served flag keeps it high
  // until the pipeline advances.
  assign if_ready  = if_served_q  | ((state_q == DONE) && (grant_q == G_IF));
  assign mem_ready = mem_served_q | ((state_q == DONE) && (grant_q == G_MEM));
  assign freeze    = (mem_req & ~mem_ready) | (if_req & ~if_ready);

  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;

  // The strobes and the bus are decoded from the state, not registered. An
  // asynchronous reset therefore releases them in the same cycle.
  assign sram_addr  = (state_q == ACCESS) ? addr_q  : '0;
  assign sram_wdata = (state_q == ACCESS) ? wdata_q : '0;
  assign sram_we_n  = ~((state_q == ACCESS) &  write_q);
  assign sram_oe_n  = ~((state_q == ACCESS) & ~write_q);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case, so paths that do
    // not assign it hold the current value instead of inferring a latch.
    state_d      = state_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    if_served_d  = if_served_q;
    mem_served_d = mem_served_q;

    unique case (state_q)
      IDLE: begin
        if (mem_req && !mem_served_q) begin
          state_d = ACCESS;
          grant_d = G_MEM;
          cnt_d   = '0;
          addr_d  = mem_addr[SRAM_ADDR_W+1:2];
          wdata_d = mem_wdata;
          write_d = mem_w_en;
        end else if (if_req && !if_served_q) begin
          state_d = ACCESS;
          grant_d = G_IF;
          cnt_d   = '0;
          addr_d  = if_addr[SRAM_ADDR_W+1:2];
          wdata_d = '0;
          write_d = 1'b0;
        end
      end

      ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          if (!write_q) begin
            if (grant_q == G_MEM) mem_rdata_d = sram_rdata;
            else                  if_rdata_d  = sram_rdata;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        grant_d = G_NONE;
        if (grant_q == G_MEM) mem_served_d = 1'b1;
        if (grant_q == G_IF)  if_served_d  = 1'b1;
      end

      default: begin
        state_d = IDLE;
        grant_d = G_NONE;
      end
    endcase

    // The pipeline advances on this edge, so the step is over. A request that
    // is still asserted is treated as a new request. This clear takes priority
    // over the set in DONE.
    if (!freeze) begin
      if_served_d  = 1'b0;
      mem_served_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= G_NONE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      // NOTE: the read-data holding registers are visible outputs and must
      // read 0 after reset. They are reset like any other state, not left
      // unreset like a storage array.
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      if_served_q  <= 1'b0;
      mem_served_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the
      // pre-edge values regardless of statement order.
      state_q      <= state_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      if_served_q  <= if_served_d;
      mem_served_q <= mem_served_d;
    end
  end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter.
// A pipeline step is described by its requests. The reference model turns it
// into a timeline of the step, built from the arbitration rules:
//   - MEM (if requested) accesses in cycles 1..W and is ready at W+1.
//   - IF follows in the next free slot.
//   - freeze is low in the first cycle in which everything is ready.
// A flat word array mirrors SRAM contents so that load data can be predicted.
module tb_mem_arbiter;

  localparam int W = 3;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic        freeze;

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .SRAM_ADDR_W(16), .WAIT_CYCLES(W)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .freeze(freeze)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] seed_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // SRAM environment: the array is written on strobes, and the bus floats to a
  // marker value when it is not output-enabled.
  logic [31:0] sram [65536];
  initial begin
    for (int i = 0; i < 65536; i++) sram[i] = seed_word(i);
    sram[2] = 32'hE3A0_0001;
    forever begin
      @(posedge clk);
      if (!sram_we_n) sram[sram_addr] = sram_wdata;
    end
  end
  assign sram_rdata = sram_oe_n ? 32'h0BAD_F00D : sram[sram_addr];

  // Reference model state.
  logic [31:0] ref_mem [65536];
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_mem_rdata;
  int          n_checks;
  int          n_fail;
  int          step_no;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Entered just after a rising edge; that cycle is cycle 0 of the step. The
  // task returns just after the edge on which the pipeline advances.
  task automatic run_step(input bit ir, input bit mr, input bit mw,
                          input logic [31:0] ia, input logic [31:0] ma,
                          input logic [31:0] wd);
    bit          has_mem;
    int          if_start;
    int          if_done;
    int          last;
    logic [15:0] m_word;
    logic [15:0] i_word;
    bit          m_acc;
    bit          i_acc;
    bit          m_rdy;
    bit          i_rdy;
    string       t;

    has_mem  = mr | mw;
    if_start = has_mem ? W + 3 : 1;
    if_done  = if_start + W;
    last     = 0;
    if (has_mem) last = W + 1;
    if (ir)      last = if_done;
    m_word   = ma[17:2];
    i_word   = ia[17:2];

    if_req = ir; if_addr = ia; mem_r_en = mr; mem_w_en = mw;
    mem_addr = ma; mem_wdata = wd;
    step_no++;

    for (int c = 0; c <= last; c++) begin
      m_acc = has_mem && c >= 1 && c <= W;
      i_acc = ir && c >= if_start && c < if_done;
      m_rdy = has_mem && c >= W + 1;
      i_rdy = ir && c >= if_done;
      if (has_mem && c == W + 1) begin
        if (mw) ref_mem[m_word] = wd;
        else    exp_mem_rdata   = ref_mem[m_word];
      end
      if (ir && c == if_done) exp_if_rdata = ref_mem[i_word];

      @(negedge clk);
      t = $sformatf("s%0d c%0d", step_no, c);
      check({t, " freeze"},    32'(freeze),    32'((has_mem && !m_rdy) || (ir && !i_rdy)));
      check({t, " if_ready"},  32'(if_ready),  32'(i_rdy));
      check({t, " mem_ready"}, 32'(mem_ready), 32'(m_rdy));
      check({t, " we_n"},      32'(sram_we_n), 32'(!(m_acc && mw)));
      check({t, " oe_n"},      32'(sram_oe_n), 32'(!(i_acc || (m_acc && !mw))));
      if (m_acc) check({t, " sram_addr"}, 32'(sram_addr), 32'(m_word));
      if (i_acc) check({t, " sram_addr"}, 32'(sram_addr), 32'(i_word));
      if (m_acc && mw) check({t, " sram_wdata"}, sram_wdata, wd);
      check({t, " if_rdata"},  if_rdata,  exp_if_rdata);
      check({t, " mem_rdata"}, mem_rdata, exp_mem_rdata);
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a       = $urandom;
    a[17:2] = 16'($urandom_range(0, 31));
    return a;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0; step_no = 0;
    exp_if_rdata = '0; exp_mem_rdata = '0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = seed_word(i);
    ref_mem[2] = 32'hE3A0_0001;

    rst = 1'b1;
    if_req = 0; if_addr = '0; mem_r_en = 0; mem_w_en = 0; mem_addr = '0; mem_wdata = '0;
    @(negedge clk);
    check("reset freeze",    32'(freeze),    32'd0);
    check("reset if_ready",  32'(if_ready),  32'd0);
    check("reset mem_ready", 32'(mem_ready), 32'd0);
    check("reset we_n",      32'(sram_we_n), 32'd1);
    check("reset oe_n",      32'(sram_oe_n), 32'd1);
    check("reset sram_addr", 32'(sram_addr), 32'd0);
    check("reset if_rdata",  if_rdata,       32'd0);
    check("reset mem_rdata", mem_rdata,      32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed steps: IF-only, store, simultaneous, re-serve, store+load.
    run_step(1, 0, 0, 32'h0000_0008, 32'h0, 32'h0);
    check("test1 if_rdata", if_rdata, 32'hE3A0_0001);
    run_step(0, 0, 1, 32'h0, 32'h0000_0400, 32'h1234_5678);
    run_step(1, 1, 0, 32'h0000_000C, 32'h0000_0400, 32'h0);
    check("test3 mem_rdata", mem_rdata, 32'h1234_5678);
    run_step(1, 1, 0, 32'h0000_0010, 32'h0000_0008, 32'h0);
    run_step(0, 1, 1, 32'h0, 32'h0000_0020, 32'hCAFE_0042);

    // Randomized steps; a narrow address range makes read-after-write common.
    for (int n = 0; n < 150; n++)
      run_step(1'($urandom), 1'($urandom), 1'($urandom), rand_addr(), rand_addr(), $urandom);

    // Reset in the second ACCESS cycle of a store, with the request held.
    begin
      logic [31:0] ra;
      logic [31:0] rd;
      ra = rand_addr(); rd = $urandom;
      if_req = 0; mem_r_en = 0; mem_w_en = 1; mem_addr = ra; mem_wdata = rd;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre-reset we_n", 32'(sram_we_n), 32'd0);
      rst = 1'b1; #1;
      check("midreset we_n",      32'(sram_we_n), 32'd1);
      check("midreset oe_n",      32'(sram_oe_n), 32'd1);
      check("midreset sram_addr", 32'(sram_addr), 32'd0);
      check("midreset wdata",     sram_wdata,     32'd0);
      check("midreset mem_ready", 32'(mem_ready), 32'd0);
      check("midreset if_ready",  32'(if_ready),  32'd0);
      check("midreset if_rdata",  if_rdata,       32'd0);
      check("midreset mem_rdata", mem_rdata,      32'd0);
      check("midreset freeze",    32'(freeze),    32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_if_rdata = '0; exp_mem_rdata = '0;
      run_step(0, 0, 1, 32'h0, ra, rd);
    end

    for (int n = 0; n < 40; n++)
      run_step(1'($urandom), 1'($urandom), 1'($urandom), rand_addr(), rand_addr(), $urandom);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_arbiter
